mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_LATENCY, default 2: cycles a granted access holds the data memory; legal range 1..7.
REQ-002 Parameter BASE_ADDR, default 1024: byte address of data memory word 0.
REQ-003 Parameter DEPTH, default 64: data memory size in 32-bit words.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 p_rd_en  input  1  pipeline MEM-stage read request.
REQ-007 p_wr_en  input  1  pipeline MEM-stage write request.
REQ-008 p_addr  input  32  pipeline byte address (ALU result).
REQ-009 p_wr_data  input  32  pipeline store value.
REQ-010 p_rd_data  output  32  pipeline load value.
REQ-011 freeze  output  1  pipeline stall.
REQ-012 a_req  input  1  aux requester access request, level.
REQ-013 a_we  input  1  aux write (1) / read (0).
REQ-014 a_addr  input  32  aux byte address.
REQ-015 a_wr_data  input  32  aux write value.
REQ-016 a_rd_data  output  32  aux read value.
REQ-017 a_ack  output  1  aux completion pulse.
REQ-018 mem_addr  output  32  data memory word index.
REQ-019 mem_wr_data  output  32  data memory write value.
REQ-020 mem_r_en  output  1  data memory read enable.
REQ-021 mem_w_en  output  1  data memory write enable.
REQ-022 mem_rd_data  input  32  data memory read value (combinational from mem_addr).
REQ-023 addr_err  output  1  sticky illegal-address flag.

Function
REQ-024 FSM states IDLE, BUSY, RESP; IDLE->BUSY on any request; BUSY->RESP after MEM_LATENCY cycles; RESP->IDLE unconditionally.
REQ-025 Pipeline request p_req = p_rd_en | p_wr_en; both asserted -> write.
REQ-026 Arbitration in IDLE only: single requester wins; both requesting -> round-robin on last_grant bit, winner = owner not granted last.
REQ-027 At grant: owner, write flag, address, and write data registered; later requester-input changes ignored until RESP.
REQ-028 Word index = (addr - BASE_ADDR) >> 2, 32-bit unsigned arithmetic; driven on mem_addr throughout BUSY.
REQ-029 Illegal address: addr < BASE_ADDR, addr[1:0] != 0, or word index >= DEPTH; access keeps full BUSY/RESP timing, mem enables stay low, read returns 0, addr_err set.
REQ-030 mem_r_en (read) or mem_w_en (write) high on every BUSY cycle, low in IDLE and RESP; mem_wr_data = latched write data in BUSY, else 0.
REQ-031 Last BUSY cycle: mem_rd_data captured into owner's read register (p_rd_data or a_rd_data); other register unchanged; writes leave both unchanged.
REQ-032 RESP: a_ack = 1 iff owner is aux; a_ack 0 otherwise.
REQ-033 freeze = p_req AND NOT (state == RESP AND owner == pipeline), combinational; pipeline access latency MEM_LATENCY+2 cycles, freeze high MEM_LATENCY+1 of them.
REQ-034 Requester deasserting after grant: access completes normally; aux a_ack still pulses.
REQ-035 No new grant in BUSY or RESP; requests arriving then wait for IDLE.

Reset
REQ-036 rst asserted: state IDLE immediately, last_grant = aux (pipeline wins first tie), counter 0, all outputs 0 (freeze follows REQ-033 combinationally), addr_err cleared.
REQ-037 Reset mid-BUSY: mem_w_en drops asynchronously, access aborted, no ack, read registers cleared.

Verification
REQ-038 Pipeline load p_addr=1032, mem_rd_data=0xDEADBEEF, MEM_LATENCY=2 -> mem_addr=2, mem_r_en 2 cycles, freeze high 3 cycles, p_rd_data=0xDEADBEEF in RESP.
REQ-039 Pipeline and aux request same cycle after reset -> pipeline served first, aux next; a_ack exactly one cycle, 4 cycles after pipeline RESP.
REQ-040 Continuous requests from both for 6 accesses -> strict P,A,P,A,P,A grant order.
REQ-041 Aux write a_addr=1020 -> no mem_w_en, a_ack after 3 cycles, addr_err=1 until reset; p_addr=1026 likewise flags.
REQ-042 Reset asserted on second BUSY cycle of pipeline store -> mem_w_en 0 same cycle, state IDLE, no RESP, outputs 0.
REQ-043 a_req dropped one cycle after grant -> access completes, a_ack pulses once.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates a pipeline MEM stage and an aux requester onto
// one data memory port. IDLE grants, BUSY holds the memory for MEM_LATENCY
// cycles, and RESP returns the result for one cycle before going back to IDLE.
module mem_access_ctrl #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned DEPTH       = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_rd_en,
  input  logic        p_wr_en,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wr_data,
  output logic [31:0] p_rd_data,
  output logic        freeze,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wr_data,
  output logic [31:0] a_rd_data,
  output logic        a_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rd_data,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [31:0] BASE     = 32'(BASE_ADDR);
  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic [2:0]  LAST_CNT = 3'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;        // 1 = aux owns the access
  logic        we_q, we_d;
  logic        bad_q, bad_d;            // latched access targets an illegal address
  logic        last_aux_q, last_aux_d;  // 1 = aux received the most recent grant
  logic        err_q, err_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p_rd_q, p_rd_d;
  logic [31:0] a_rd_q, a_rd_d;

  logic        p_req;
  logic        grant_aux;
  logic        sel_we;
  logic        sel_bad;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] sel_idx;
  logic [31:0] rd_val;

  // Requester selection and address decode for a grant taken this cycle
  always_comb begin
    p_req     = p_rd_en | p_wr_en;
    // On a tie the requester that was not granted last time wins.
    grant_aux = a_req & (~p_req | ~last_aux_q);
    sel_addr  = grant_aux ? a_addr : p_addr;
    sel_we    = grant_aux ? a_we : p_wr_en;
    sel_wdata = grant_aux ? a_wr_data : p_wr_data;
    sel_idx   = (sel_addr - BASE) >> 2;
    sel_bad   = (sel_addr < BASE) || (sel_addr[1:0] != 2'b00) || (sel_idx >= DEPTH_W);
    // Illegal accesses never sample the memory and return zero.
    rd_val    = bad_q ? 32'd0 : mem_rd_data;
  end

  // Next-state logic: grant in IDLE, count BUSY cycles, capture on the last one
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    bad_d      = bad_q;
    last_aux_d = last_aux_q;
    err_d      = err_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    p_rd_d     = p_rd_q;
    a_rd_d     = a_rd_q;
    case (state_q)
      S_IDLE: begin
        if (p_req || a_req) begin
          state_d    = S_BUSY;
          cnt_d      = 3'd0;
          owner_d    = grant_aux;
          we_d       = sel_we;
          bad_d      = sel_bad;
          idx_d      = sel_idx;
          wdata_d    = sel_wdata;
          last_aux_d = grant_aux;
          err_d      = err_q | sel_bad;
        end
      end
      S_BUSY: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_q) a_rd_d = rd_val;
            else         p_rd_d = rd_val;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      bad_q      <= 1'b0;
      last_aux_q <= 1'b1;
      err_q      <= 1'b0;
      idx_q      <= 32'd0;
      wdata_q    <= 32'd0;
      p_rd_q     <= 32'd0;
      a_rd_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      bad_q      <= bad_d;
      last_aux_q <= last_aux_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      p_rd_q     <= p_rd_d;
      a_rd_q     <= a_rd_d;
    end
  end

  // Outputs decoded from registered state only, so reset clears them at once
  always_comb begin
    mem_addr    = (state_q == S_BUSY) ? idx_q : 32'd0;
    mem_wr_data = (state_q == S_BUSY) ? wdata_q : 32'd0;
    mem_r_en    = (state_q == S_BUSY) & ~we_q & ~bad_q;
    mem_w_en    = (state_q == S_BUSY) & we_q & ~bad_q;
    a_ack       = (state_q == S_RESP) & owner_q;
    freeze      = p_req & ~((state_q == S_RESP) & ~owner_q);
    p_rd_data   = p_rd_q;
    a_rd_data   = a_rd_q;
    addr_err    = err_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of single accesses, hand-written multi-cycle
// sequences, and random accesses checked against a transaction-level model.
module tb_mem_access_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_rd_en, p_wr_en, a_req, a_we;
  logic [31:0] p_addr, p_wr_data, a_addr, a_wr_data;
  logic [31:0] p_rd_data, a_rd_data, mem_addr, mem_wr_data, mem_rd_data;
  logic        freeze, a_ack, mem_r_en, mem_w_en, addr_err;

  logic        use_arr = 1'b0;
  logic        mem_init = 1'b0;
  logic [31:0] rd_val = 32'd0;
  logic [31:0] mem_arr [64];

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LATENCY(LAT), .BASE_ADDR(1024), .DEPTH(64)) dut (
    .clk(clk), .rst(rst),
    .p_rd_en(p_rd_en), .p_wr_en(p_wr_en), .p_addr(p_addr), .p_wr_data(p_wr_data),
    .p_rd_data(p_rd_data), .freeze(freeze),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data), .a_ack(a_ack),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .mem_rd_data(mem_rd_data), .addr_err(addr_err)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5000000 + 32'(i) * 32'h00010203;
  endfunction

  // Data memory environment: combinational read, clocked write
  assign mem_rd_data = use_arr ? mem_arr[mem_addr[5:0]] : rd_val;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else if (mem_w_en) begin
      mem_arr[mem_addr[5:0]] <= mem_wr_data;
    end
  end

  typedef struct {
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wd;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wd, rd_val;
    logic        e_aux, e_ren, e_wen, e_err;
    logic [31:0] e_idx, e_wd, e_prd, e_ard;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p_rd_en = 0; p_wr_en = 0; p_addr = 0; p_wr_data = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wr_data = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    idle_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  // One access from an IDLE cycle through RESP, checked cycle by cycle
  task automatic run_access(input vec_t v);
    logic preq;
    preq = v.p_rd | v.p_wr;
    @(negedge clk);
    p_rd_en = v.p_rd; p_wr_en = v.p_wr; p_addr = v.p_addr; p_wr_data = v.p_wd;
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wr_data = v.a_wd;
    rd_val = v.rd_val;
    #1 chk("freeze_req", {31'd0, freeze}, {31'd0, preq});
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk("busy_mem_addr", mem_addr, v.e_idx);
      chk("busy_r_en", {31'd0, mem_r_en}, {31'd0, v.e_ren});
      chk("busy_w_en", {31'd0, mem_w_en}, {31'd0, v.e_wen});
      if (v.e_wen) chk("busy_wr_data", mem_wr_data, v.e_wd);
      chk("busy_freeze", {31'd0, freeze}, {31'd0, preq});
      chk("busy_ack", {31'd0, a_ack}, 32'd0);
    end
    @(negedge clk);
    chk("resp_ack", {31'd0, a_ack}, {31'd0, v.e_aux});
    chk("resp_r_en", {31'd0, mem_r_en}, 32'd0);
    chk("resp_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("resp_freeze", {31'd0, freeze}, {31'd0, preq & v.e_aux});
    chk("resp_p_rd_data", p_rd_data, v.e_prd);
    chk("resp_a_rd_data", a_rd_data, v.e_ard);
    chk("resp_addr_err", {31'd0, addr_err}, {31'd0, v.e_err});
    $display("txn %0d owner=%s we=%0d idx=%h p_rd=%h a_rd=%h err=%0d", n_txn,
             v.e_aux ? "aux" : "pipe", v.e_wen, v.e_idx, p_rd_data, a_rd_data, addr_err);
    n_txn++;
    idle_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 255)) * 4;
    if (r == 1) return 32'd1024 + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
    if (r == 2) return 32'd1280 + 32'($urandom_range(0, 100)) * 4;
    return 32'd1024 + 32'($urandom_range(0, 63)) * 4;
  endfunction

  // Reference model state for the random phase
  logic [31:0] m_mem [64];
  logic        m_last_aux, m_err;
  logic [31:0] m_prd, m_ard;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_rd_data", p_rd_data, 32'd0);
    chk("rst_a_rd_data", a_rd_data, 32'd0);
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk("rst_r_en", {31'd0, mem_r_en}, 32'd0);
    chk("rst_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    chk("rst_freeze", {31'd0, freeze}, 32'd0);
    @(negedge clk);
    rst = 0;

    // Single accesses, each from reset (pipeline wins the first tie)
    tbl[0] = '{1, 0, 1032, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0, 0, 2, 0, 32'hDEADBEEF, 0};
    tbl[1] = '{0, 1, 1028, 32'h11112222, 0, 0, 0, 0, 32'h77, 0, 0, 1, 0, 1, 32'h11112222, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 0, 1276, 0, 32'hCAFEF00D, 1, 1, 0, 0, 63, 0, 0, 32'hCAFEF00D};
    tbl[3] = '{0, 0, 0, 0, 1, 1, 1020, 32'h99, 32'h88, 1, 0, 0, 1, 32'h3FFFFFFF, 0, 0, 0};
    tbl[4] = '{1, 0, 1026, 0, 0, 0, 0, 0, 32'h55, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[5] = '{1, 0, 1040, 0, 1, 0, 1044, 0, 32'h0BADF00D, 0, 1, 0, 0, 4, 0, 32'h0BADF00D, 0};
    tbl[6] = '{1, 1, 1036, 32'hABCD0123, 0, 0, 0, 0, 32'h66, 0, 0, 1, 0, 3, 32'hABCD0123, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 1, 0, 1280, 0, 32'h44, 1, 0, 0, 1, 64, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_access(tbl[i]);
    end

    // Simultaneous requests after reset: pipeline first, aux acked 4 cycles later
    do_reset();
    rd_val = 32'h600DF00D;
    @(negedge clk);
    p_rd_en = 1; p_addr = 1032; a_req = 1; a_we = 0; a_addr = 1036;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      chk("tie_a_ack", {31'd0, a_ack}, {31'd0, cyc == 7});
      if (cyc == 1) chk("tie_first_addr", mem_addr, 32'd2);
      if (cyc == 5) chk("tie_second_addr", mem_addr, 32'd3);
      if (cyc == 3) begin
        chk("tie_p_resp_freeze", {31'd0, freeze}, 32'd0);
        chk("tie_p_rd_data", p_rd_data, 32'h600DF00D);
        p_rd_en = 0;
      end
      if (cyc == 7) begin
        chk("tie_a_rd_data", a_rd_data, 32'h600DF00D);
        a_req = 0;
      end
    end

    // Continuous requests from both: grants alternate P,A,P,A,P,A
    do_reset();
    @(negedge clk);
    p_rd_en = 1; p_addr = 1032; a_req = 1; a_we = 0; a_addr = 1036;
    for (int cyc = 1; cyc < 24; cyc++) begin
      @(negedge clk);
      if (cyc % 4 == 1) chk("rr_grant_addr", mem_addr, ((cyc / 4) % 2 == 1) ? 32'd3 : 32'd2);
      if (cyc % 4 == 3) begin
        chk("rr_ack", {31'd0, a_ack}, {31'd0, (cyc / 4) % 2 == 1});
        chk("rr_freeze", {31'd0, freeze}, {31'd0, (cyc / 4) % 2 == 1});
      end
    end
    idle_inputs();

    // Reset on the second BUSY cycle of a pipeline store
    do_reset();
    v = '{1, 0, 1032, 0, 0, 0, 0, 0, 32'h12345678, 0, 1, 0, 0, 2, 0, 32'h12345678, 0};
    run_access(v);
    @(negedge clk);
    p_wr_en = 1; p_addr = 1040; p_wr_data = 32'hFEEDFACE;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_w_en_before", {31'd0, mem_w_en}, 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_mid_w_en_drop", {31'd0, mem_w_en}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    chk("rst_mid_p_rd_data", p_rd_data, 32'd0);
    p_wr_en = 0;
    @(negedge clk);
    rst = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", {31'd0, a_ack}, 32'd0);
      chk("rst_mid_no_w_en", {31'd0, mem_w_en}, 32'd0);
      chk("rst_mid_freeze", {31'd0, freeze}, 32'd0);
    end
    v = '{0, 0, 0, 0, 1, 0, 1100, 0, 32'h31415926, 1, 1, 0, 0, 19, 0, 0, 32'h31415926};
    run_access(v);

    // Aux request dropped one cycle after grant still completes with one ack
    do_reset();
    rd_val = 32'h43434343;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 1048;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) a_req = 0;
      chk("drop_a_ack", {31'd0, a_ack}, {31'd0, cyc == 3});
      if (cyc == 3) chk("drop_a_rd_data", a_rd_data, 32'h43434343);
    end

    // Random accesses against the transaction-level model
    do_reset();
    @(negedge clk);
    mem_init = 1;
    @(negedge clk);
    mem_init = 0;
    use_arr = 1;
    for (int i = 0; i < 64; i++) m_mem[i] = init_word(i);
    m_last_aux = 1; m_err = 0; m_prd = 0; m_ard = 0;
    for (int it = 0; it < 60; it++) begin
      int pk;
      logic aa, pp, aux_wins, we, bad;
      logic [31:0] addr, wd, idx;
      pk = $urandom_range(0, 2);
      aa = (pk == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pp = (pk != 0);
      v.p_wr = (pk == 2);
      v.p_rd = (pk == 1) || ((pk == 2) && ($urandom_range(0, 1) == 1));
      v.p_addr = rand_addr();
      v.p_wd = $urandom;
      v.a_req = aa;
      v.a_we = 1'($urandom_range(0, 1));
      v.a_addr = rand_addr();
      v.a_wd = $urandom;
      v.rd_val = 0;
      aux_wins = aa && (!pp || !m_last_aux);
      addr = aux_wins ? v.a_addr : v.p_addr;
      we = aux_wins ? v.a_we : v.p_wr;
      wd = aux_wins ? v.a_wd : v.p_wd;
      idx = (addr - 32'd1024) / 4;
      bad = (addr < 32'd1024) || (addr % 4 != 0) || (idx >= 32'd64);
      if (!we) begin
        if (aux_wins) m_ard = bad ? 32'd0 : m_mem[idx[5:0]];
        else          m_prd = bad ? 32'd0 : m_mem[idx[5:0]];
      end else if (!bad) begin
        m_mem[idx[5:0]] = wd;
      end
      m_err = m_err | bad;
      m_last_aux = aux_wins;
      v.e_aux = aux_wins;
      v.e_ren = !we && !bad;
      v.e_wen = we && !bad;
      v.e_err = m_err;
      v.e_idx = idx;
      v.e_wd = wd;
      v.e_prd = m_prd;
      v.e_ard = m_ard;
      run_access(v);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
